// File: rtl/hex_marquee_if.sv
// Load port for hex_marquee: one 32-bit message word per valid/ready handshake.
interface hex_marquee_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/hex_marquee.sv
// Eight-digit 7-segment marquee: loads a nibble message, then rotates or blinks it.
// Define HEX_MARQUEE_DP_EN to add the dp_load port and per-digit decimal points.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BLANK | nothing loaded since reset, all digits dark
// ST_LOAD  | one cycle: captured word moves into the display buffer
// ST_RUN   | divider runs; ticks rotate or blink the message by mode
module hex_marquee #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    hex_marquee_if.slave  load_if,
`ifdef HEX_MARQUEE_DP_EN
    input  logic [7:0]    dp_load,
`endif
    input  logic [1:0]    mode,
    input  logic [2:0]    rotation,
    output logic [7:0]    seg0,
    output logic [7:0]    seg1,
    output logic [7:0]    seg2,
    output logic [7:0]    seg3,
    output logic [7:0]    seg4,
    output logic [7:0]    seg5,
    output logic [7:0]    seg6,
    output logic [7:0]    seg7
);

    localparam logic [31:0] BASE_DIV = 32'(CLK_HZ / STEP_HZ);

    typedef enum logic [1:0] {ST_BLANK, ST_LOAD, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      cap_q, cap_d;
    logic [31:0]      buf_q, buf_d;
    logic [7:0]       dp_cap_q, dp_cap_d;
    logic [7:0]       dp_q, dp_d;
    logic             phase_q, phase_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [2:0]       rot_q;
    logic [7:0][7:0]  seg_q, seg_d;

    logic [7:0]  dp_in;
    logic [31:0] period;
    logic        accept;
    logic        tick;
    logic        blank;

`ifdef HEX_MARQUEE_DP_EN
    assign dp_in = dp_load;
`else
    assign dp_in = 8'h00;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    assign load_if.load_ready = (state_q != ST_LOAD);
    assign accept = load_if.load_valid && load_if.load_ready;
    // Blink darkness is gated by the live mode so leaving blink shows data at once.
    assign blank  = phase_q && (mode == 2'b11);

    always_comb begin
        period = BASE_DIV >> rotation;
        if (period == 32'd0) period = 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        buf_d    = buf_q;
        dp_cap_d = dp_cap_q;
        dp_d     = dp_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        tick     = 1'b0;

        if (accept) begin
            cap_d    = load_if.load_data;
            dp_cap_d = dp_in;
            state_d  = ST_LOAD;
        end

        case (state_q)
            ST_LOAD: begin
                buf_d   = cap_q;
                dp_d    = dp_cap_q;
                cnt_d   = 32'd0;
                phase_d = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rotation != rot_q || accept) begin
                    cnt_d = 32'd0;
                end else if (cnt_q == period - 32'd1) begin
                    cnt_d = 32'd0;
                    tick  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (tick) begin
                    case (mode)
                        2'b01: begin
                            buf_d = {buf_q[27:0], buf_q[31:28]};
                            dp_d  = {dp_q[6:0], dp_q[7]};
                        end
                        2'b10: begin
                            buf_d = {buf_q[3:0], buf_q[31:4]};
                            dp_d  = {dp_q[0], dp_q[7:1]};
                        end
                        2'b11:   phase_d = ~phase_q;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase

        if (mode != 2'b11) phase_d = 1'b0;

        // During LOAD the display holds, so a first load never flashes stale zeros.
        if (state_q == ST_BLANK) begin
            seg_d = {8{8'hFF}};
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < 8; k++) begin
                if (blank) begin
                    seg_d[k] = 8'hFF;
                end else begin
`ifdef HEX_MARQUEE_DP_EN
                    seg_d[k] = {~dp_q[k], hex7(buf_q[4*k +: 4])};
`else
                    seg_d[k] = {1'b1, hex7(buf_q[4*k +: 4])};
`endif
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_BLANK;
            cap_q    <= 32'd0;
            buf_q    <= 32'd0;
            dp_cap_q <= 8'd0;
            dp_q     <= 8'd0;
            phase_q  <= 1'b0;
            cnt_q    <= 32'd0;
            rot_q    <= 3'd0;
            seg_q    <= {8{8'hFF}};
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            buf_q    <= buf_d;
            dp_cap_q <= dp_cap_d;
            dp_q     <= dp_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            rot_q    <= rotation;
            seg_q    <= seg_d;
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];

endmodule

// File: tb/tb_hex_marquee.sv
// Directed bench for hex_marquee with CLK_HZ=64, STEP_HZ=8 (eight-cycle base step).
module tb_hex_marquee;
    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic [2:0] rotation;
    logic [7:0] dp_drv;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [63:0] segs;

    int n_checks = 0;
    int n_pass   = 0;

    hex_marquee_if lif ();

    hex_marquee #(.CLK_HZ(64), .STEP_HZ(8)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .load_if  (lif),
`ifdef HEX_MARQUEE_DP_EN
        .dp_load  (dp_drv),
`endif
        .mode     (mode),
        .rotation (rotation),
        .seg0     (seg0),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .seg4     (seg4),
        .seg5     (seg5),
        .seg6     (seg6),
        .seg7     (seg7)
    );

    assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
        logic [7:0] t;
        case (n)
            4'h0: t = 8'hC0; 4'h1: t = 8'hF9; 4'h2: t = 8'hA4; 4'h3: t = 8'hB0;
            4'h4: t = 8'h99; 4'h5: t = 8'h92; 4'h6: t = 8'h82; 4'h7: t = 8'hF8;
            4'h8: t = 8'h80; 4'h9: t = 8'h90; 4'hA: t = 8'h88; 4'hB: t = 8'h83;
            4'hC: t = 8'hC6; 4'hD: t = 8'hA1; 4'hE: t = 8'h86; default: t = 8'h8E;
        endcase
        if (dp) t[7] = 1'b0;
        return t;
    endfunction

    function automatic logic [63:0] exp_segs(input logic [31:0] w, input logic [7:0] dp);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = seg_of(w[4*k +: 4], dp[k]);
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] w);
        return {w[27:0], w[31:28]};
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] w);
        return {w[3:0], w[31:4]};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [63:0] DARK = {8{8'hFF}};

    initial begin
        logic [31:0] w1, w2, d;
        logic [7:0]  dp2, dp2_rot;
        logic [63:0] seen;

        w1 = 32'h7654_3210;
        w2 = 32'h89AB_CDEF;
`ifdef HEX_MARQUEE_DP_EN
        dp2 = 8'h01;
`else
        dp2 = 8'h00;
`endif
        dp2_rot = {dp2[6:0], dp2[7]};

        reset_n = 1'b0; lif.load_valid = 1'b0; lif.load_data = 32'd0;
        mode = 2'b00; rotation = 3'd0; dp_drv = 8'h00;

        cycles(3);
        check_eq("rst_segs", segs, DARK);
        check_eq("rst_ready", 64'(lif.load_ready), 64'd1);
        reset_n = 1'b1;

        seen = DARK;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (segs !== DARK && seen === DARK) seen = segs;
        end
        check_eq("idle_dark", seen, DARK);

        // static load
        lif.load_valid = 1'b1; lif.load_data = w1;
        cycles(1);
        lif.load_valid = 1'b0;
        check_eq("acc_ready_low", 64'(lif.load_ready), 64'd0);
        cycles(1);
        check_eq("load_ready_back", 64'(lif.load_ready), 64'd1);
        check_eq("lat_not_yet", segs, DARK);
        cycles(1);
        check_eq("load_show", segs, exp_segs(w1, 8'h00));
        seen = exp_segs(w1, 8'h00);
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (segs !== exp_segs(w1, 8'h00) && seen === exp_segs(w1, 8'h00)) seen = segs;
            if (lif.load_ready !== 1'b1) seen = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        check_eq("static_hold", seen, exp_segs(w1, 8'h00));

        // rotate left, P=8
        mode = 2'b01; lif.load_valid = 1'b1; lif.load_data = w1;
        cycles(1);
        lif.load_valid = 1'b0;
        cycles(9);
        check_eq("rotl_pre", segs, exp_segs(w1, 8'h00));
        cycles(1);
        check_eq("rotl_1", segs, exp_segs(rotl(w1), 8'h00));
        cycles(55);
        check_eq("rotl_7", segs, exp_segs(rotr(w1), 8'h00));
        cycles(1);
        check_eq("rotl_8", segs, exp_segs(w1, 8'h00));

        // rotate right, P=4, then clamp to P=1
        mode = 2'b10; rotation = 3'd1;
        cycles(5);
        check_eq("rotr_pre", segs, exp_segs(w1, 8'h00));
        cycles(1);
        check_eq("rotr_p4", segs, exp_segs(rotr(w1), 8'h00));
        rotation = 3'd7;
        cycles(2);
        check_eq("clamp_no_tick", segs, exp_segs(rotr(w1), 8'h00));
        cycles(1);
        check_eq("clamp_t1", segs, exp_segs(rotr(rotr(w1)), 8'h00));
        cycles(1);
        check_eq("clamp_t2", segs, exp_segs(rotr(rotr(rotr(w1))), 8'h00));

        // blink, P=8
        d = rotr(rotr(rotr(rotr(w1))));
        mode = 2'b11; rotation = 3'd0;
        cycles(9);
        check_eq("blink_on", segs, exp_segs(d, 8'h00));
        cycles(1);
        check_eq("blink_dark", segs, DARK);
        cycles(7);
        check_eq("blink_dark_hold", segs, DARK);
        cycles(1);
        check_eq("blink_on2", segs, exp_segs(d, 8'h00));
        cycles(8);
        check_eq("blink_dark2", segs, DARK);
        mode = 2'b00;
        cycles(1);
        check_eq("blink_exit", segs, exp_segs(d, 8'h00));

        // load colliding with a due tick, valid held through LOAD
        mode = 2'b01;
        cycles(13);
        check_eq("pre_collide", segs, exp_segs(rotl(d), 8'h00));
        lif.load_valid = 1'b1; lif.load_data = w2; dp_drv = dp2;
        cycles(1);
        check_eq("collide_ready", 64'(lif.load_ready), 64'd0);
        cycles(1);
        check_eq("collide_ready_back", 64'(lif.load_ready), 64'd1);
        check_eq("collide_no_rot", segs, exp_segs(rotl(d), 8'h00));
        cycles(1);
        lif.load_valid = 1'b0;
        check_eq("reaccept", 64'(lif.load_ready), 64'd0);
        check_eq("collide_load", segs, exp_segs(w2, dp2));
        cycles(9);
        check_eq("restart_pre", segs, exp_segs(w2, dp2));
        cycles(1);
        check_eq("restart_tick", segs, exp_segs(rotl(w2), dp2_rot));

        // asynchronous reset mid-rotation
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_segs", segs, DARK);
        check_eq("async_rst_ready", 64'(lif.load_ready), 64'd1);
        cycles(1);
        reset_n = 1'b1;
        cycles(10);
        check_eq("post_rst_dark", segs, DARK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
